mux_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the 7-to-1 switch multiplexer. Seven requesters raise individual request lines. The block grants exactly one requester at a time and drives the mux's 3-bit select so the granted source reaches the output. It sits between the request sources and the mux select input, and parks the mux on the unused code 3'b111 (mux output 0) whenever nobody owns it.

---
 rtl/mux_rr_arbiter_pkg.sv | 22 ++
 rtl/mux_rr_arbiter_if.sv | 14 +
 rtl/mux_rr_arbiter_rr_pick.sv | 27 ++
 rtl/mux_rr_arbiter.sv | 138 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and constants for the 7-to-1 mux round-robin arbiter.
package mux_rr_arbiter_pkg;

    localparam int unsigned NUM_REQ = 7;
    localparam int unsigned SEL_W   = 3;

    // Select code 7 is not wired to any source, so the mux outputs 0.
    localparam logic [SEL_W-1:0] PARK_SEL = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StGap
    } state_e;

    typedef logic [NUM_REQ-1:0] grant_t;

    function automatic grant_t onehot(logic [SEL_W-1:0] idx);
        return grant_t'(1) << idx;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/grant/select bundle between the request sources, the arbiter and the mux.
interface mux_rr_arbiter_if;
    import mux_rr_arbiter_pkg::*;

    logic [NUM_REQ-1:0] req;
    grant_t             grant;
    logic [SEL_W-1:0]   mux_select;
    logic               valid;
    logic               timeout;

    modport master (output req, input grant, mux_select, valid, timeout);
    modport slave  (input req, output grant, mux_select, valid, timeout);

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin search (rr_pick): first set request after `last`, wrapping 6 -> 0.
module mux_rr_arbiter_rr_pick
    import mux_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               found,
    output logic [SEL_W-1:0]   winner
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        found  = 1'b0;
        winner = PARK_SEL;
        idx    = '0;
        // k = NUM_REQ revisits `last` itself, so a sole previous owner is still found.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = SEL_W'((32'(last) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter/sequencer driving the 7-to-1 mux select; parks on code 7 when idle.
// Optional owner hold limit enabled by defining MUX_RR_ARBITER_TIMEOUT_EN.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16
) (
    input logic              clk,
    input logic              rst_n,
    mux_rr_arbiter_if.slave  bus
);

    if (HOLD_MAX < 2 || HOLD_MAX > 256) begin : g_hold_check
        $error("HOLD_MAX must be within 2..256");
    end

    state_e           state_q, state_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    grant_t           grant_q, grant_d;
    logic             valid_q, valid_d;

    logic             found;
    logic [SEL_W-1:0] winner;
    logic             owner_req;
    logic             hold_expired;

    mux_rr_arbiter_rr_pick u_rr_pick (
        .req    (bus.req),
        .last   (last_q),
        .found  (found),
        .winner (winner)
    );

    // In GRANT, last_q is the current owner.
    assign owner_req = bus.req[last_q];

`ifdef MUX_RR_ARBITER_TIMEOUT_EN
    localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    assign hold_expired = (hold_q == HoldLast);
`else
    assign hold_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        valid_d = valid_q;
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            StIdle, StGap: begin
                if (found) begin
                    state_d = StGrant;
                    last_d  = winner;
                    sel_d   = winner;
                    grant_d = onehot(winner);
                    valid_d = 1'b1;
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end else begin
                    state_d = StIdle;
                    sel_d   = PARK_SEL;
                    grant_d = '0;
                    valid_d = 1'b0;
                end
            end
            StGrant: begin
                // Every release goes through one parked GAP cycle, even with others waiting.
                if (!owner_req || hold_expired) begin
                    state_d = StGap;
                    sel_d   = PARK_SEL;
                    grant_d = '0;
                    valid_d = 1'b0;
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
                    timeout_d = owner_req;
`endif
                end else begin
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
                    hold_d = hold_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d = StIdle;
                sel_d   = PARK_SEL;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            last_q  <= SEL_W'(NUM_REQ - 1);
            sel_q   <= PARK_SEL;
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
        end
    end

`ifdef MUX_RR_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.grant      = grant_q;
    assign bus.mux_select = sel_q;
    assign bus.valid      = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed vector table, hand sequences, random vs model.
module tb_mux_rr_arbiter;
    import mux_rr_arbiter_pkg::*;

    localparam int HOLD = 4;
    localparam logic [11:0] PARKED = {7'b0, 3'b111, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mux_rr_arbiter_if bus ();

    mux_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        logic [6:0] req;
        logic [6:0] grant;
        logic [2:0] sel;
        logic       valid;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: owner index (-1 = parked) and a priority list rotated after each grant.
    int m_owner;
    int m_order[$];
    int m_held;
    bit m_tmo;

    function automatic void model_reset();
        m_owner = -1;
        m_order = {0, 1, 2, 3, 4, 5, 6};
        m_held  = 0;
        m_tmo   = 1'b0;
    endfunction

    function automatic void model_step(logic [6:0] r);
        bit tmo_n;
        bit rel;
        tmo_n = 1'b0;
        if (m_owner >= 0) begin
            rel = !r[m_owner];
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
            if (!rel && m_held == HOLD - 1) begin
                rel   = 1'b1;
                tmo_n = 1'b1;
            end
`endif
            if (rel) m_owner = -1;
            else m_held++;
        end else begin
            foreach (m_order[i]) begin
                if (m_owner < 0 && r[m_order[i]]) m_owner = m_order[i];
            end
            if (m_owner >= 0) begin
                m_held = 0;
                while (m_order[m_order.size()-1] != m_owner)
                    m_order.push_back(m_order.pop_front());
            end
        end
        m_tmo = tmo_n;
    endfunction

    function automatic logic [11:0] model_out();
        logic [6:0] g;
        logic [2:0] s;
        g = '0;
        s = 3'b111;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            s = 3'(m_owner);
        end
        return {g, s, (m_owner >= 0), m_tmo};
    endfunction

    function automatic logic [11:0] dut_out();
        return {bus.grant, bus.mux_select, bus.valid, bus.timeout};
    endfunction

    task automatic check(string name, logic [11:0] act, logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got grant/sel/valid/tmo=%b_%b_%b_%b want %b_%b_%b_%b", name,
                     act[11:5], act[4:2], act[1], act[0], exp[11:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    task automatic cycle(logic [6:0] r);
        bus.req = r;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        bus.req = '0;
        model_reset();
        #1;
        check("reset_state", dut_out(), PARKED);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic void add(bit rst, logic [6:0] req, logic [6:0] g, logic [2:0] s,
                                logic v);
        vec_t t;
        t.rst = rst; t.req = req; t.grant = g; t.sel = s; t.valid = v;
        vecs.push_back(t);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] oh;
        logic [6:0] r;
        logic [11:0] exp;

        bus.req = '0;
        model_reset();

        // Single request, latency 1, release parks next cycle.
        add(1, 7'b0000100, 7'b0000100, 3'd2, 1'b1);
        add(0, 7'b0000100, 7'b0000100, 3'd2, 1'b1);
        add(0, 7'b0000000, 7'b0000000, 3'd7, 1'b0);
        add(0, 7'b0000000, 7'b0000000, 3'd7, 1'b0);
        // All requesting, owner drops for one cycle: order 0..6 then 0.
        for (int i = 0; i < 8; i++) begin
            oh = 7'b0000001 << (i % 7);
            add(i == 0, 7'h7f, oh, 3'(i % 7), 1'b1);
            add(0, 7'h7f & ~oh, 7'b0, 3'd7, 1'b0);
        end
        // No preemption, then wrap 6 -> 0.
        add(1, 7'b1000000, 7'b1000000, 3'd6, 1'b1);
        add(0, 7'b1100001, 7'b1000000, 3'd6, 1'b1);
        add(0, 7'b0100001, 7'b0000000, 3'd7, 1'b0);
        add(0, 7'b0100001, 7'b0000001, 3'd0, 1'b1);
        // Sole requester re-raises in GAP; then drop-plus-new-request still goes via GAP.
        add(1, 7'b0010000, 7'b0010000, 3'd4, 1'b1);
        add(0, 7'b0000000, 7'b0000000, 3'd7, 1'b0);
        add(0, 7'b0010000, 7'b0010000, 3'd4, 1'b1);
        add(0, 7'b0001000, 7'b0000000, 3'd7, 1'b0);
        add(0, 7'b0001000, 7'b0001000, 3'd3, 1'b1);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            cycle(vecs[i].req);
            check($sformatf("vec%0d", i), dut_out(),
                  {vecs[i].grant, vecs[i].sel, vecs[i].valid, 1'b0});
        end

        // Asynchronous reset mid-grant parks without a clock edge.
        do_reset();
        cycle(7'b0001000);
        check("async_pre", dut_out(), {7'b0001000, 3'd3, 1'b1, 1'b0});
        cycle(7'b0001000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_park", dut_out(), PARKED);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(7'b0001000);
        check("async_regrant", dut_out(), {7'b0001000, 3'd3, 1'b1, 1'b0});

        // Hold limit with two steady requesters.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            cycle(7'b0000110);
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
            if (c < 4) exp = {7'b0000010, 3'd1, 1'b1, 1'b0};
            else if (c == 4 || c == 9) exp = {7'b0, 3'd7, 1'b0, 1'b1};
            else exp = {7'b0000100, 3'd2, 1'b1, 1'b0};
`else
            exp = {7'b0000010, 3'd1, 1'b1, 1'b0};
`endif
            check($sformatf("hold%0d", c), dut_out(), exp);
        end

        // Random sticky requests against the model.
        do_reset();
        r = '0;
        for (int n = 0; n < 2000; n++) begin
            for (int b = 0; b < 7; b++) begin
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            end
            if ($urandom_range(63) == 0) r = '0;
            cycle(r);
            check($sformatf("rand%0d", n), dut_out(), model_out());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
